// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the parametrised floating-point adder.
//   - exp_bias / exp_max: exponent bias and all-ones exponent code for a
//     given exponent field width.
//   - GRS_W: number of guard/round/sticky bits carried below the mantissa
//     LSB through alignment and normalisation (0 when rounding is truncation).
// Build option: FPADD_RNE_EN selects round-to-nearest-even (GRS_W = 3).
package fp_pkg;

`ifdef FPADD_RNE_EN
    localparam int unsigned GRS_W = 3;
`else
    localparam int unsigned GRS_W = 0;
`endif

    function automatic int unsigned exp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned exp_max(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_norm_param.sv
// fp_norm_param: combinational normaliser for the adder's S3 stage.
// Ports:
//   mant_in  [MAN_W+GRS_W+1:0] raw sum with carry bit at the top
//   exp_in   [EXP_W-1:0]       exponent of the larger operand
//   mant_out [MAN_W+GRS_W:0]   normalised mantissa, hidden bit at the top
//                              (top bit 0 means the sum was zero)
//   exp_out  [EXP_W-1:0]       low bits of the adjusted exponent
//   exp_ovf / exp_unf          adjusted exponent >= all-ones / <= 0
// Build option: FPADD_RNE_EN keeps a sticky bit on the carry right-shift.
module fp_norm_param
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
)(
    input  logic [MAN_W+GRS_W+1:0] mant_in,
    input  logic [EXP_W-1:0]       exp_in,
    output logic [MAN_W+GRS_W:0]   mant_out,
    output logic [EXP_W-1:0]       exp_out,
    output logic                   exp_ovf,
    output logic                   exp_unf
);
    localparam int SW  = MAN_W + GRS_W + 2;
    localparam int MW  = SW - 1;
    localparam int LZW = $clog2(SW);
    localparam int EW2 = EXP_W + 2;
    localparam logic signed [EW2-1:0] EXP_TOP = EW2'(exp_max(EXP_W));

    logic [LZW-1:0]         lzc;
    logic signed [EW2-1:0]  exp_full;

    always_comb begin
        // highest set bit below the carry position wins
        lzc = LZW'(SW - 1);
        for (int i = 0; i < SW - 1; i++) begin
            if (mant_in[i]) lzc = LZW'(SW - 2 - i);
        end
        if (mant_in[SW-1]) begin
            mant_out = mant_in[SW-1:1];
`ifdef FPADD_RNE_EN
            mant_out[0] = mant_in[1] | mant_in[0];
`endif
            exp_full = EW2'(exp_in) + EW2'(1);
        end else begin
            mant_out = mant_in[MW-1:0] << lzc;
            exp_full = EW2'(exp_in) - EW2'(lzc);
        end
        exp_out = exp_full[EXP_W-1:0];
        exp_ovf = !exp_full[EW2-1] && (exp_full >= EXP_TOP);
        exp_unf = exp_full[EW2-1] || (exp_full == '0);
    end

endmodule

// File: rtl/fpadd_pipe_param.sv
// fpadd_pipe_param: 3-stage pipelined floating-point adder/subtractor.
//   S1 capture/swap, S2 align/add, S3 normalise/pack (output register).
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready, a, b, sub (1: a-b), in_tag  -- operation in
//   out_valid/out_ready, result, out_tag, ovf, unf -- result out
// All stages advance together when the output is empty or being taken,
// so in_ready is that same enable. Denormal inputs are flushed to zero.
// Build option: FPADD_RNE_EN rounds to nearest-even instead of truncating.
module fpadd_pipe_param
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   ovf,
    output logic                   unf
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int MW = M + GRS_W;
    localparam int SW = MW + 1;
    localparam int unsigned SHIFT_LIM = MAN_W + 2;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             zero_sign;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    mant;
        logic [TAG_W-1:0] tag;
    } stage_t;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1: flush denormals, apply sub to b's sign, order by magnitude
    logic           a_zero, b_zero, b_sign, swap;
    logic [W-2:0]   a_mag, b_mag;
    logic [M-1:0]   a_man, b_man;

    always_comb begin
        a_zero = (a[W-2:MAN_W] == '0);
        b_zero = (b[W-2:MAN_W] == '0);
        a_mag  = a_zero ? '0 : a[W-2:0];
        b_mag  = b_zero ? '0 : b[W-2:0];
        a_man  = a_zero ? '0 : {1'b1, a[MAN_W-1:0]};
        b_man  = b_zero ? '0 : {1'b1, b[MAN_W-1:0]};
        b_sign = b[W-1] ^ sub;
        swap   = b_mag > a_mag;
    end

    logic             s1_valid, s1_sign_x, s1_sign_y;
    logic [EXP_W-1:0] s1_exp_x, s1_exp_y;
    logic [M-1:0]     s1_man_x, s1_man_y;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sign_x <= 1'b0;
            s1_sign_y <= 1'b0;
            s1_exp_x  <= '0;
            s1_exp_y  <= '0;
            s1_man_x  <= '0;
            s1_man_y  <= '0;
            s1_tag    <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_tag   <= in_tag;
            if (swap) begin
                s1_sign_x <= b_sign;
                s1_exp_x  <= b[W-2:MAN_W];
                s1_man_x  <= b_man;
                s1_sign_y <= a[W-1];
                s1_exp_y  <= a[W-2:MAN_W];
                s1_man_y  <= a_man;
            end else begin
                s1_sign_x <= a[W-1];
                s1_exp_x  <= a[W-2:MAN_W];
                s1_man_x  <= a_man;
                s1_sign_y <= b_sign;
                s1_exp_y  <= b[W-2:MAN_W];
                s1_man_y  <= b_man;
            end
        end
    end

    // S2: align the smaller operand and add/subtract magnitudes
    logic [EXP_W-1:0] shift;
    logic [MW-1:0]    x_ext, y_ext, y_al;
    logic             same;
    logic [SW-1:0]    sum;

    always_comb begin
        shift = s1_exp_x - s1_exp_y;
        x_ext = MW'(s1_man_x) << GRS_W;
        y_ext = MW'(s1_man_y) << GRS_W;
        y_al  = '0;
        if (32'(shift) < SHIFT_LIM) begin
            y_al = y_ext >> shift;
`ifdef FPADD_RNE_EN
            y_al[0] = y_al[0] | (|(y_ext & ~({MW{1'b1}} << shift)));
`endif
        end
        same = (s1_sign_x == s1_sign_y);
        sum  = same ? ({1'b0, x_ext} + {1'b0, y_al})
                    : ({1'b0, x_ext} - {1'b0, y_al});
    end

    stage_t s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2 <= '0;
        end else if (en) begin
            s2.valid     <= s1_valid;
            s2.sign      <= s1_sign_x;
            // a zero sum is -0 only when both inputs were -0
            s2.zero_sign <= same ? s1_sign_x : 1'b0;
            s2.exp       <= s1_exp_x;
            s2.mant      <= sum;
            s2.tag       <= s1_tag;
        end
    end

    // S3: normalise, round, pack
    logic [MW-1:0]    norm_mant;
    logic [EXP_W-1:0] norm_exp;
    logic             norm_ovf, norm_unf;

    fp_norm_param #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm (
        .mant_in  (s2.mant),
        .exp_in   (s2.exp),
        .mant_out (norm_mant),
        .exp_out  (norm_exp),
        .exp_ovf  (norm_ovf),
        .exp_unf  (norm_unf)
    );

    logic [MAN_W-1:0] frac_r;
    logic [EXP_W-1:0] exp_r;
    logic             ovf_r;
`ifdef FPADD_RNE_EN
    logic             rnd, rcarry;
`endif

    always_comb begin
`ifdef FPADD_RNE_EN
        rnd    = norm_mant[2] & (norm_mant[1] | norm_mant[0] | norm_mant[GRS_W]);
        frac_r = norm_mant[MW-2:GRS_W] + MAN_W'(rnd);
        rcarry = rnd & (&norm_mant[MW-2:GRS_W]);
        exp_r  = norm_exp + EXP_W'(rcarry);
        ovf_r  = norm_ovf | (rcarry & (norm_exp == EXP_W'(exp_max(EXP_W) - 1)));
`else
        frac_r = norm_mant[MW-2:0];
        exp_r  = norm_exp;
        ovf_r  = norm_ovf;
`endif
    end

    logic [W-1:0] res_n;
    logic         ovf_n, unf_n;

    always_comb begin
        res_n = {s2.sign, exp_r, frac_r};
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (!norm_mant[MW-1]) begin
            res_n = {s2.zero_sign, {(W-1){1'b0}}};
        end else if (norm_unf) begin
            res_n = '0;
            unf_n = 1'b1;
        end else if (ovf_r) begin
            res_n = {s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else if (en) begin
            out_valid <= s2.valid;
            result    <= res_n;
            out_tag   <= s2.tag;
            ovf       <= ovf_n;
            unf       <= unf_n;
        end
    end

endmodule

// File: tb/tb_fpadd_pipe_param.sv
module tb_fpadd_pipe_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        sub;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic [3:0]  out_tag;
    logic        ovf, unf;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    fpadd_pipe_param #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // value-level model: returns {ovf, unf, result}
    function automatic logic [33:0] model_add(input logic [31:0] fa, fb, input logic fs);
        logic [31:0] x, y;
        logic sa, sb, sx, sy;
        logic [30:0] ka, kb;
        int ex, ey, d, e, e_pre, p, sh;
        longint unsigned mx, my, xs, ys, s, keep;
`ifdef FPADD_RNE_EN
        longint unsigned rem, half;
`endif
        sa = fa[31];
        sb = fb[31] ^ fs;
        ka = (fa[30:23] == 8'd0) ? 31'd0 : fa[30:0];
        kb = (fb[30:23] == 8'd0) ? 31'd0 : fb[30:0];
        if (kb > ka) begin x = fb; sx = sb; y = fa; sy = sa; end
        else         begin x = fa; sx = sa; y = fb; sy = sb; end
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = (ex == 0) ? 64'd0 : (64'd1 << 23) + 64'(x[22:0]);
        my = (ey == 0) ? 64'd0 : (64'd1 << 23) + 64'(y[22:0]);
        d  = ex - ey;
`ifdef FPADD_RNE_EN
        if (d >= 25) begin xs = mx; ys = 0; e = ex; end
        else begin xs = mx << d; ys = my; e = ex - d; end
`else
        xs = mx;
        ys = (d >= 25) ? 64'd0 : (my >> d);
        e  = ex;
`endif
        s = (sx == sy) ? xs + ys : xs - ys;
        if (s == 0) return {2'b00, ((sx == sy) ? sx : 1'b0), 31'd0};
        p = 0;
        for (int i = 0; i < 64; i++) if (s[i]) p = i;
        if (p > 23) begin
            sh = p - 23;
            keep = s >> sh;
            e = e + sh;
            e_pre = e;
`ifdef FPADD_RNE_EN
            rem  = s & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
            if (keep == (64'd1 << 24)) begin keep = keep >> 1; e = e + 1; end
`endif
        end else begin
            keep = s << (23 - p);
            e = e - (23 - p);
            e_pre = e;
        end
        if (e_pre <= 0) return {2'b01, 32'd0};
        if (e >= 255)   return {2'b10, sx, 8'hFF, 23'd0};
        return {2'b00, sx, e[7:0], keep[22:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: expected entries are {tag, ovf, unf, result}
    logic [37:0] exp_q[$];
    logic [37:0] held, got, want;
    logic        hold_pending = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back({in_tag, model_add(a, b, sub)});
            got = {out_tag, ovf, unf, result};
            if (out_valid) begin
                if (hold_pending) begin
                    n_tests++;
                    if (got !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %0h, expected %0h", got, held);
                    end
                end
                if (out_ready) begin
                    hold_pending = 1'b0;
                    n_out++;
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL scoreboard: unexpected result tag=%0h res=%08h", out_tag, result);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            n_fail++;
                            $display("FAIL scoreboard: got tag=%0h ovf=%0b unf=%0b res=%08h, expected tag=%0h ovf=%0b unf=%0b res=%08h",
                                     got[37:34], got[33], got[32], got[31:0],
                                     want[37:34], want[33], want[32], want[31:0]);
                        end
                    end
                end else begin
                    held = got;
                    hold_pending = 1'b1;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    // caller is just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [31:0] ta, tb, input logic ts, input logic [3:0] tg);
        int k;
        in_valid = 1'b1; a = ta; b = tb; sub = ts; in_tag = tg;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin @(negedge clk); k++; end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic direct(input logic [31:0] ta, tb, input logic ts, input logic [3:0] tg,
                          input logic [31:0] er, input logic eo, eu);
        int n;
        chk("model_pin", 64'(model_add(ta, tb, ts)), 64'({eo, eu, er}));
        send(ta, tb, ts, tg);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk("latency", 64'(n), 64'd3);
        chk("result", 64'(result), 64'(er));
        chk("tag", 64'(out_tag), 64'(tg));
        chk("ovf", 64'(ovf), 64'(eo));
        chk("unf", 64'(unf), 64'(eu));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] va, vb;
        logic        vs;
        logic [3:0]  vt;
        logic [31:0] vr;
        logic        vo, vu;
    } vec_t;

    vec_t vecs[14];
    logic bp_done;
    int   n0, k;

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 4'd5,  32'h40000000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 4'd1,  32'h00000000, 1'b0, 1'b0};
        vecs[2]  = '{32'hC0400000, 32'h40400000, 1'b0, 4'd2,  32'h00000000, 1'b0, 1'b0};
        vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd3,  32'h7F800000, 1'b1, 1'b0};
        vecs[4]  = '{32'h00800001, 32'h80800000, 1'b0, 4'd4,  32'h00000000, 1'b0, 1'b1};
        vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 4'd6,  32'h3F800000, 1'b0, 1'b0};
`ifdef FPADD_RNE_EN
        vecs[6]  = '{32'h3F800001, 32'h33800000, 1'b0, 4'd7,  32'h3F800002, 1'b0, 1'b0};
        vecs[13] = '{32'h3F800000, 32'hB3800000, 1'b0, 4'd14, 32'h3F7FFFFF, 1'b0, 1'b0};
`else
        vecs[6]  = '{32'h3F800001, 32'h33800000, 1'b0, 4'd7,  32'h3F800001, 1'b0, 1'b0};
        vecs[13] = '{32'h3F800000, 32'hB3800000, 1'b0, 4'd14, 32'h3F800000, 1'b0, 1'b0};
`endif
        vecs[7]  = '{32'h00000000, 32'hC0000000, 1'b1, 4'd8,  32'h40000000, 1'b0, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 4'd9,  32'h80000000, 1'b0, 1'b0};
        vecs[9]  = '{32'h00000000, 32'h00000000, 1'b1, 4'd10, 32'h00000000, 1'b0, 1'b0};
        vecs[10] = '{32'h3F800000, 32'h40000000, 1'b1, 4'd11, 32'hBF800000, 1'b0, 1'b0};
        vecs[11] = '{32'h40400000, 32'h3FC00000, 1'b0, 4'd12, 32'h40900000, 1'b0, 1'b0};
        vecs[12] = '{32'h00000001, 32'h3F800000, 1'b0, 4'd13, 32'h3F800000, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; in_tag = '0;
        #23;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_flags", 64'({ovf, unf}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        foreach (vecs[i])
            direct(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].vt,
                   vecs[i].vr, vecs[i].vo, vecs[i].vu);

        // backpressure: four back-to-back ops while the consumer stalls
        n0 = n_out;
        out_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0, 4'd1);
                send(32'h3F800000, 32'h40000000, 1'b1, 4'd2);
                send(32'h40400000, 32'h3FC00000, 1'b0, 4'd3);
                send(32'h00000000, 32'hC0000000, 1'b1, 4'd4);
                bp_done = 1'b1;
            end
        join_none
        repeat (6) @(posedge clk);
        #2;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_tag", 64'(out_tag), 64'd1);
        out_ready = 1'b1;
        k = 0;
        while (!bp_done && k < 100) begin @(posedge clk); k++; end
        chk("bp_send_done", 64'(bp_done), 64'd1);
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        chk("bp_drain", 64'(exp_q.size()), 64'd0);
        chk("bp_count", 64'(n_out - n0), 64'd4);

        // reset with two operations in flight
        send(32'h3F800000, 32'h3F800000, 1'b0, 4'd6);
        send(32'h40400000, 32'h3FC00000, 1'b0, 4'd7);
        @(posedge clk); #1;
        n0 = n_out;
        chk("mid_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_no_stale", 64'(n_out - n0), 64'd0);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        direct(32'h3F800000, 32'h3F800000, 1'b0, 4'd15, 32'h40000000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
